// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit (master) and instruction memory (slave).
// The fetch unit holds MEM_READ high until the cycle MEM_READY is seen with MEM_DATA valid.
interface instr_fetch_unit_if;
    logic [31:0] MEM_ADDR;
    logic        MEM_READ;
    logic [31:0] MEM_DATA;
    logic        MEM_READY;

    modport master (
        output MEM_ADDR,
        output MEM_READ,
        input  MEM_DATA,
        input  MEM_READY
    );

    modport slave (
        input  MEM_ADDR,
        input  MEM_READ,
        output MEM_DATA,
        output MEM_READY
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and field-split stage: PC, memory request FSM and instruction register.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_STEP        = 32'd1,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    instr_fetch_unit_if.master          mem,
    input  logic                        ADVANCE,
    output logic [5:0]                  OpCode,
    output logic [4:0]                  Rs,
    output logic [4:0]                  Rt,
    output logic [4:0]                  Rd,
    output logic [4:0]                  Shamt,
    output logic [5:0]                  Funct,
    output logic [15:0]                 Imm,
    output logic [31:0]                 PC,
    output logic                        INSTR_VALID,
    output logic                        FETCH_ERR,
    output logic [1:0]                  dbg_state_o
);

    localparam logic [31:0] NOP_WORD = 32'hFC00_0000;
    localparam logic [5:0]  NOP_OP   = 6'h3F;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] mem_addr_q;
    logic        mem_read_q;
    logic        valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr_q;
    logic          err_q;
`endif

    // A fetched NOP is never completed by the control unit, so HOLD releases it itself.
    logic hold_release;
    assign hold_release = ADVANCE || (ir_q[31:26] == NOP_OP);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            ir_q       <= NOP_WORD;
            mem_addr_q <= RESET_PC;
            mem_read_q <= 1'b0;
            valid_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmr_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    mem_addr_q <= pc_q;
                    mem_read_q <= 1'b1;
                    state_q    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    tmr_q      <= '0;
`endif
                end
                S_WAIT: begin
                    if (mem.MEM_READY) begin
                        ir_q       <= mem.MEM_DATA;
                        mem_read_q <= 1'b0;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_q + PC_STEP;
                        state_q    <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // READY on the final allowed cycle is taken above, ahead of the timeout.
                    else if (tmr_q == TMR_LAST) begin
                        mem_read_q <= 1'b0;
                        err_q      <= 1'b1;
                        state_q    <= S_ERR;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
`endif
                end
                S_HOLD: begin
                    if (hold_release) begin
                        ir_q    <= NOP_WORD;
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_ERR: begin
                    mem_read_q <= 1'b0;
                    ir_q       <= NOP_WORD;
                    valid_q    <= 1'b0;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign mem.MEM_ADDR = mem_addr_q;
    assign mem.MEM_READ = mem_read_q;

    assign OpCode      = ir_q[31:26];
    assign Rs          = ir_q[25:21];
    assign Rt          = ir_q[20:16];
    assign Rd          = ir_q[15:11];
    assign Shamt       = ir_q[10:6];
    assign Funct       = ir_q[5:0];
    assign Imm         = ir_q[15:0];
    assign PC          = pc_q;
    assign INSTR_VALID = valid_q;
    assign dbg_state_o = state_q;

`ifdef FETCH_TIMEOUT_EN
    assign FETCH_ERR = err_q;
`else
    assign FETCH_ERR = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch and field-split stage sitting directly upstream of the control unit. It holds the PC, reads one 32-bit instruction word per handshake from instruction memory, and latches it into an instruction register. It presents OpCode/Shamt/Funct and register addresses to the control unit, and advances to the next instruction when the control unit signals completion. When no valid instruction is held, it presents the NOP opcode (63).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetched word (word-addressed memory)
TIMEOUT_CYCLES, 16, cycles allowed in WAIT before fetch error (used only with the optional feature)

Ports:
CLK  input  1  clock, rising-edge active
RST  input  1  asynchronous active-low reset
MEM_ADDR  output  32  instruction memory address, registered
MEM_READ  output  1  memory read request, registered
MEM_DATA  input  32  instruction word from memory
MEM_READY  input  1  MEM_DATA valid this cycle
ADVANCE  input  1  control unit done with current instruction (driven from its WRITE)
OpCode  output  6  IR[31:26]
Rs  output  5  IR[25:21]
Rt  output  5  IR[20:16]
Rd  output  5  IR[15:11]
Shamt  output  5  IR[10:6]
Funct  output  6  IR[5:0]
Imm  output  16  IR[15:0]
PC  output  32  address of next word to fetch
INSTR_VALID  output  1  IR holds a fetched instruction
FETCH_ERR  output  1  sticky fetch timeout flag

Behaviour:
- One clock CLK; reset RST asynchronous, active-low. All state updates on posedge CLK, except reset.
- Reset (RST=0, immediate and held): PC=RESET_PC, MEM_ADDR=RESET_PC, MEM_READ=0, IR=32'hFC00_0000 (so OpCode=63, all other fields 0), INSTR_VALID=0, FETCH_ERR=0, state=REQ.
- All field outputs are direct slices of IR, so they change only when IR is written.
- States: REQ, WAIT, HOLD, ERR.
  - REQ: MEM_ADDR<=PC, MEM_READ<=1; go to WAIT. MEM_READY is ignored in REQ.
  - WAIT: MEM_READY=1 -> IR<=MEM_DATA, MEM_READ<=0, INSTR_VALID<=1, PC<=PC+PC_STEP; go to HOLD. Otherwise stay in WAIT with MEM_READ held at 1.
  - HOLD: IR is stable. ADVANCE=1 -> IR<=NOP word, INSTR_VALID<=0; go to REQ.
  - HOLD, fetched OpCode==63: the control unit never completes a NOP, so HOLD advances on the next edge without ADVANCE, with the same updates as above.
  - ERR: terminal until reset. MEM_READ=0, IR=NOP word, INSTR_VALID=0.
- ADVANCE is ignored in REQ, WAIT and ERR.
- Latency: from entering REQ to INSTR_VALID=1 is at minimum 2 edges (REQ, then WAIT with READY already high).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFF + 1 wraps to 0.
- Reset asserted mid-WAIT: MEM_READ drops asynchronously. Any in-flight memory response is ignored, because the fetch restarts in REQ.

Optional Feature:
Macro FETCH_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle without MEM_READY. When it reaches TIMEOUT_CYCLES: MEM_READ<=0, FETCH_ERR<=1, go to ERR. A READY in the same cycle as the count reaching TIMEOUT_CYCLES wins, and the fetch completes normally.
- Undefined: no counter, WAIT waits indefinitely, ERR is unreachable, FETCH_ERR tied 0. The port exists in both builds.

Test Plan:
- Reset: RST=0 during WAIT -> same cycle MEM_READ=0; after release PC=0, OpCode=63, INSTR_VALID=0, FETCH_ERR=0; next edge MEM_READ=1, MEM_ADDR=0.
- Normal fetch: MEM_READY high on the 3rd WAIT cycle with MEM_DATA=32'h0022_1820 -> OpCode=0, Rs=1, Rt=2, Rd=3, Shamt=0, Funct=6'h20, Imm=16'h1820, PC=1, INSTR_VALID=1, MEM_READ=0.
- Advance: ADVANCE=1 for one cycle in HOLD -> next edge OpCode=63, INSTR_VALID=0; following edge MEM_ADDR=1, MEM_READ=1. ADVANCE pulsed during WAIT has no effect.
- NOP fetch: MEM_DATA=32'hFC00_0000 -> INSTR_VALID=1 for exactly one cycle, then auto-return to REQ with MEM_ADDR=1, with ADVANCE held 0 throughout.
- Wrap: RESET_PC=32'hFFFF_FFFF, one fetch -> PC=0, next MEM_ADDR=0.
- Timeout (FETCH_TIMEOUT_EN): MEM_READY held 0 -> after 16 WAIT cycles FETCH_ERR=1, MEM_READ=0, and the block stays in ERR despite later MEM_READY or ADVANCE. Without the macro: no error after 100 cycles, MEM_READ remains 1.
